fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised single-clock synchronous FIFO: the next generation of the team's FIFO. It is generalised in data width and depth, has configurable almost-full/almost-empty thresholds and a live occupancy count, and offers a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It reports per-cycle write acknowledge, overflow and underflow status for scoreboard checking.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of storage entries (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-1, almostfull asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almostempty asserts when 0 < count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out  out  WIDTH  read data
- wr_ack  out  1  registered: previous-cycle write accepted
- overflow  out  1  registered: previous-cycle write rejected because full
- underflow  out  1  registered: previous-cycle read rejected because empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almostfull  out  1  count ≥ AF_LEVEL
- almostempty  out  1  0 < count ≤ AE_LEVEL
- count  out  CW  current occupancy

## Operation
- State: memory [DEPTH][WIDTH] (not reset), wr_ptr, rd_ptr (0..DEPTH-1), count (0..DEPTH), data_out register (standard mode only).
- Write accepted when wr_en && !full: mem[wr_ptr] ← data_in; wr_ptr advances, wrapping DEPTH-1 → 0.
- Read accepted when rd_en && !empty: rd_ptr advances with the same wrap. In standard mode, data_out ← mem[rd_ptr].
- count: +1 on write-only accepted, −1 on read-only accepted, unchanged when both are accepted or neither is.
- Simultaneous wr_en && rd_en:
  - empty: write only, underflow=1
  - full: read only, overflow=1
  - otherwise both accepted, wr_ack=1
- Rejected write: no memory or pointer change; overflow=1 next cycle.
- Rejected read: no pointer change; data_out holds; underflow=1 next cycle.
- wr_ack, overflow and underflow are one-cycle pulses. Each is recomputed every edge and cleared if the condition is absent.
- FWFT=1: data_out = mem[rd_ptr] combinationally, so the head word is visible while !empty. data_out is don't-care while empty. rd_en acts as the pop.
- Flags full, empty, almostfull, almostempty are combinational decodes of count.

## Timing
- Reset (async assert, sync-safe deassert): wr_ptr=rd_ptr=count=0, data_out=0 (standard mode), wr_ack=overflow=underflow=0, empty=1, full=0, almostfull=0 (AF_LEVEL≥1), almostempty=0.
- Reset asserted mid-operation clears everything immediately, with no clock needed. Stored data is discarded. The first post-reset write lands at index 0.
- Write latency: data written at edge N is readable from edge N+1. Standard mode: a read at edge N+1 puts it on data_out after N+1. FWFT: it appears on data_out right after edge N.
- Standard read latency: 1 cycle from the accepting edge.
- Flags and count reflect the state after the most recent edge. Status pulses describe the request sampled at the previous edge.
- Pointer wrap: index DEPTH-1 → 0 with no bubble. Full and empty are distinguished by count, never by pointer equality.

## Test plan
Defaults: WIDTH=16, DEPTH=8, AF_LEVEL=7, AE_LEVEL=1, FWFT=0 unless stated.
- Fill/drain: 8 writes 0x0001..0x0008, then 8 reads → wr_ack each write; full=1 and count=8 after the 8th write; reads return 0x0001..0x0008 in order; empty=1 and count=0 at end; almostfull=1 at count 7 and 8; almostempty=1 at count 1 only.
- Overflow/underflow: write 0xAAAA when full → overflow=1 for one cycle, count stays 8, 0xAAAA is never read. Read when empty → underflow=1, data_out holds its last value.
- Simultaneous: both enables while empty → count=1, underflow=1. Both while full → count=7, overflow=1. Both at count=4 → count stays 4, wr_ack=1, FIFO order preserved.
- Wrap-around: repeat 20× (write, read) with incrementing data → every read matches, count never exceeds 1, pointers wrap twice.
- Reset mid-stream: 5 writes, assert rst_n=0 between edges → outputs at reset values immediately. After release, write 0x1234 then read → 0x1234.
- FWFT=1, DEPTH=5: write 0x00A5 → data_out=0x00A5 the cycle after the write with no rd_en; a pop exposes the next word the same cycle; a 10000-cycle random run matches the reference model.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with configurable depth, threshold flags, occupancy count
// and an optional first-word-fall-through read port.
module fifo_sync_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             wr_ack,
  output logic             overflow,
  output logic             underflow,
  output logic             full,
  output logic             empty,
  output logic             almostfull,
  output logic             almostempty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance is judged on the pre-edge occupancy, so a simultaneous
  // request on an empty/full FIFO degrades to write-only/read-only.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C);
  assign almostempty = (count != '0) && (count <= AE_C);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_out <= '0;
        else if (rd_ok) data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a default standard-mode instance and a
// DEPTH=5 first-word-fall-through instance checked against a queue model.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [15:0] a_din = '0;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [15:0] a_dout;
  logic        a_ack, a_ovf, a_unf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  logic [15:0] f_din = '0;
  logic        f_wr = 1'b0, f_rd = 1'b0;
  logic [15:0] f_dout;
  logic        f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
  logic [2:0]  f_cnt;

  always #5 clk = ~clk;

  fifo_sync_param u_std (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_unf),
    .full(a_full), .empty(a_empty), .almostfull(a_af), .almostempty(a_ae),
    .count(a_cnt)
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
    .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
    .count(f_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic        e_ack, e_ovf, e_unf, w_ok, r_ok;

  initial begin
    // reset state
    #2;
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_pulses", {29'd0, a_ack, a_ovf, a_unf}, 0);
    chk("rst_af_ae", {30'd0, a_af, a_ae}, 0);
    #10 rst_n = 1'b1;

    // fill / drain
    for (int i = 1; i <= 8; i++) begin
      a_din = 16'(i); a_wr = 1'b1;
      cyc();
      chk("fill_ack", 32'(a_ack), 1);
      chk("fill_count", 32'(a_cnt), 32'(i));
      chk("fill_af", 32'(a_af), 32'(i >= 7));
      chk("fill_ae", 32'(a_ae), 32'(i == 1));
      chk("fill_full", 32'(a_full), 32'(i == 8));
    end
    a_wr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a_rd = 1'b1;
      cyc();
      chk("drain_data", 32'(a_dout), 32'(i));
      chk("drain_count", 32'(a_cnt), 32'(8 - i));
      chk("drain_ae", 32'(a_ae), 32'(i == 7));
      chk("drain_empty", 32'(a_empty), 32'(i == 8));
    end
    a_rd = 1'b0;

    // overflow / underflow
    for (int i = 0; i < 8; i++) begin
      a_din = 16'h11 + 16'(i); a_wr = 1'b1;
      cyc();
    end
    chk("ovf_pre_full", 32'(a_full), 1);
    a_din = 16'hAAAA;
    cyc();
    chk("ovf_pulse", 32'(a_ovf), 1);
    chk("ovf_noack", 32'(a_ack), 0);
    chk("ovf_count", 32'(a_cnt), 8);
    a_wr = 1'b0;
    cyc();
    chk("ovf_clear", 32'(a_ovf), 0);
    for (int i = 0; i < 8; i++) begin
      a_rd = 1'b1;
      cyc();
      chk("ovf_drain", 32'(a_dout), 32'h11 + 32'(i));
    end
    cyc();
    chk("unf_pulse", 32'(a_unf), 1);
    chk("unf_hold", 32'(a_dout), 32'h18);
    a_rd = 1'b0;
    cyc();
    chk("unf_clear", 32'(a_unf), 0);

    // simultaneous requests
    a_din = 16'h0055; a_wr = 1'b1; a_rd = 1'b1;
    cyc();
    chk("sim_empty_count", 32'(a_cnt), 1);
    chk("sim_empty_unf", 32'(a_unf), 1);
    chk("sim_empty_ack", 32'(a_ack), 1);
    a_rd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_din = 16'h61 + 16'(i);
      cyc();
    end
    chk("sim_full_pre", 32'(a_cnt), 8);
    a_din = 16'hBBBB; a_rd = 1'b1;
    cyc();
    chk("sim_full_count", 32'(a_cnt), 7);
    chk("sim_full_ovf", 32'(a_ovf), 1);
    chk("sim_full_data", 32'(a_dout), 32'h55);
    a_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sim_mid_data", 32'(a_dout), 32'h61 + 32'(i));
    end
    chk("sim_mid_count", 32'(a_cnt), 4);
    a_din = 16'h0077; a_wr = 1'b1;
    cyc();
    chk("sim4_count", 32'(a_cnt), 4);
    chk("sim4_ack", 32'(a_ack), 1);
    chk("sim4_data", 32'(a_dout), 32'h64);
    a_wr = 1'b0;
    cyc(); chk("sim4_order0", 32'(a_dout), 32'h65);
    cyc(); chk("sim4_order1", 32'(a_dout), 32'h66);
    cyc(); chk("sim4_order2", 32'(a_dout), 32'h67);
    cyc(); chk("sim4_order3", 32'(a_dout), 32'h77);
    a_rd = 1'b0;
    chk("sim4_empty", 32'(a_empty), 1);

    // wrap-around
    for (int k = 0; k < 20; k++) begin
      a_din = 16'h0100 + 16'(k); a_wr = 1'b1;
      cyc();
      chk("wrap_count1", 32'(a_cnt), 1);
      a_wr = 1'b0; a_rd = 1'b1;
      cyc();
      chk("wrap_data", 32'(a_dout), 32'h100 + 32'(k));
      chk("wrap_count0", 32'(a_cnt), 0);
      a_rd = 1'b0;
    end

    // reset mid-stream
    for (int i = 1; i <= 5; i++) begin
      a_din = 16'h0200 + 16'(i); a_wr = 1'b1;
      f_din = 16'h0300 + 16'(i); f_wr = 1'b1;
      cyc();
    end
    a_wr = 1'b0; f_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_count", 32'(a_cnt), 0);
    chk("mrst_empty", 32'(a_empty), 1);
    chk("mrst_ack", 32'(a_ack), 0);
    chk("mrst_dout", 32'(a_dout), 0);
    chk("mrst_fwft_empty", 32'(f_empty), 1);
    #2 rst_n = 1'b1;
    a_din = 16'h1234; a_wr = 1'b1;
    cyc();
    a_wr = 1'b0; a_rd = 1'b1;
    cyc();
    chk("mrst_data", 32'(a_dout), 32'h1234);
    chk("mrst_count0", 32'(a_cnt), 0);
    a_rd = 1'b0;

    // FWFT directed
    f_din = 16'h00A5; f_wr = 1'b1;
    cyc();
    chk("fwft_show", 32'(f_dout), 32'hA5);
    chk("fwft_count", 32'(f_cnt), 1);
    f_wr = 1'b0;
    cyc();
    chk("fwft_hold", 32'(f_dout), 32'hA5);
    f_din = 16'h00B6; f_wr = 1'b1;
    cyc();
    chk("fwft_head", 32'(f_dout), 32'hA5);
    f_wr = 1'b0; f_rd = 1'b1;
    cyc();
    chk("fwft_pop_next", 32'(f_dout), 32'hB6);
    chk("fwft_pop_count", 32'(f_cnt), 1);
    cyc();
    chk("fwft_empty", 32'(f_empty), 1);
    f_rd = 1'b0;

    // FWFT random run against a queue model
    for (int n = 0; n < 10000; n++) begin
      f_wr  = 1'($urandom_range(0, 1));
      f_rd  = 1'($urandom_range(0, 1));
      f_din = 16'($urandom);
      w_ok  = f_wr && (q.size() < 5);
      r_ok  = f_rd && (q.size() > 0);
      e_ack = w_ok;
      e_ovf = f_wr && (q.size() == 5);
      e_unf = f_rd && (q.size() == 0);
      if (r_ok) void'(q.pop_front());
      if (w_ok) q.push_back(f_din);
      cyc();
      chk("rnd_count", 32'(f_cnt), 32'(q.size()));
      chk("rnd_pulses", {29'd0, f_ack, f_ovf, f_unf}, {29'd0, e_ack, e_ovf, e_unf});
      chk("rnd_flags", {28'd0, f_full, f_empty, f_af, f_ae},
          {28'd0, q.size() == 5, q.size() == 0, q.size() >= 4, q.size() == 1});
      if (q.size() > 0) chk("rnd_data", 32'(f_dout), 32'(q[0]));
    end
    f_wr = 1'b0; f_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
